// File: rtl/tour_pkg.sv
// Shared types and constants for the knight's-tour command replay path.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package tour_pkg;

   // Replay sequencer states: one command leg is issued, then we wait for its response.
   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      VERT      = 3'd1,
      VERT_WAIT = 3'd2,
      HORZ      = 3'd3,
      HORZ_WAIT = 3'd4
   } state_t;

   // Robot headings carried in cmd[11:4]
   localparam logic [7:0] HDG_N = 8'h00;
   localparam logic [7:0] HDG_W = 8'h3F;
   localparam logic [7:0] HDG_S = 8'h7F;
   localparam logic [7:0] HDG_E = 8'hBF;

   // Opcodes carried in cmd[15:12]
   localparam logic [3:0] OP_MOVE_DEF    = 4'h2;
   localparam logic [3:0] OP_FANFARE_DEF = 4'h3;

   // Response bytes toward the host
   localparam logic [7:0] RESP_ACK  = 8'hA5;
   localparam logic [7:0] RESP_BUSY = 8'h5A;

   localparam int NUM_MOVES_DEF = 24;

   // Assemble a command word {opcode, heading, squares}
   function automatic logic [15:0] mk_cmd(input logic [3:0] op,
                                          input logic [7:0] hdg,
                                          input logic [3:0] sq);
      return {op, hdg, sq};
   endfunction

endpackage

// File: rtl/tour_move_decode.sv
// Splits a one-hot knight move into a vertical leg and a horizontal leg.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the output simply follows move.
module tour_move_decode
   import tour_pkg::*;
(
   input  logic [7:0] move,
   output logic [7:0] vert_hdg,
   output logic [3:0] vert_sq,
   output logic [7:0] horz_hdg,
   output logic [3:0] horz_sq
);

   // Table lookup per knight direction; zero or multi-hot moves give zero-length legs
   // so the replay handshake still runs to completion without moving the robot.
   always_comb begin
      vert_hdg = HDG_N;
      vert_sq  = 4'd0;
      horz_hdg = HDG_N;
      horz_sq  = 4'd0;
      case (move)
         8'h01: begin vert_hdg = HDG_N; vert_sq = 4'd2; horz_hdg = HDG_W; horz_sq = 4'd1; end
         8'h02: begin vert_hdg = HDG_N; vert_sq = 4'd2; horz_hdg = HDG_E; horz_sq = 4'd1; end
         8'h04: begin vert_hdg = HDG_N; vert_sq = 4'd1; horz_hdg = HDG_W; horz_sq = 4'd2; end
         8'h08: begin vert_hdg = HDG_S; vert_sq = 4'd1; horz_hdg = HDG_W; horz_sq = 4'd2; end
         8'h10: begin vert_hdg = HDG_S; vert_sq = 4'd2; horz_hdg = HDG_W; horz_sq = 4'd1; end
         8'h20: begin vert_hdg = HDG_S; vert_sq = 4'd2; horz_hdg = HDG_E; horz_sq = 4'd1; end
         8'h40: begin vert_hdg = HDG_S; vert_sq = 4'd1; horz_hdg = HDG_E; horz_sq = 4'd2; end
         8'h80: begin vert_hdg = HDG_N; vert_sq = 4'd1; horz_hdg = HDG_E; horz_sq = 4'd2; end
         default: begin
            vert_hdg = HDG_N;
            vert_sq  = 4'd0;
            horz_hdg = HDG_N;
            horz_sq  = 4'd0;
         end
      endcase
   end

endmodule

// File: rtl/tour_cmd_sequencer.sv
// Replays a solved knight's tour as move/fanfare commands, muxed with UART commands.
// Latency: cmd_rdy rises the cycle after start_tour and the cycle after send_resp.
// Backpressure: each leg holds cmd/cmd_rdy until clr_cmd_rdy, then waits for send_resp.
module tour_cmd_sequencer
   import tour_pkg::*;
#(
   parameter int         NUM_MOVES  = NUM_MOVES_DEF,
   parameter logic [3:0] OP_MOVE    = OP_MOVE_DEF,
   parameter logic [3:0] OP_FANFARE = OP_FANFARE_DEF
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start_tour,
   input  logic [7:0]  move,
   output logic [4:0]  mv_indx,
   input  logic [15:0] cmd_UART,
   input  logic        cmd_rdy_UART,
   input  logic        clr_cmd_rdy,
   output logic        clr_cmd_rdy_UART,
   input  logic        send_resp,
   output logic [15:0] cmd,
   output logic        cmd_rdy,
   output logic [7:0]  resp
);

   localparam logic [4:0] LAST_IDX = 5'(NUM_MOVES - 1);

   state_t      state;
   state_t      nxt_state;
   logic [4:0]  nxt_indx;
   logic [7:0]  vert_hdg;
   logic [3:0]  vert_sq;
   logic [7:0]  horz_hdg;
   logic [3:0]  horz_sq;
   logic [15:0] vert_cmd;
   logic [15:0] horz_cmd;
   logic        last_move;

   tour_move_decode u_decode (
      .move     (move),
      .vert_hdg (vert_hdg),
      .vert_sq  (vert_sq),
      .horz_hdg (horz_hdg),
      .horz_sq  (horz_sq)
   );

   // The solver output is stable for a given index, so both legs stay stable while offered.
   assign vert_cmd  = mk_cmd(OP_MOVE, vert_hdg, vert_sq);
   assign horz_cmd  = mk_cmd(OP_FANFARE, horz_hdg, horz_sq);
   assign last_move = (mv_indx == LAST_IDX);

   // State register and replay index; reset aborts any replay in progress.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         mv_indx <= 5'd0;
      end else begin
         state   <= nxt_state;
         mv_indx <= nxt_indx;
      end
   end

   // Next-state logic and output mux: UART passes through only while idle.
   always_comb begin
      nxt_state        = state;
      nxt_indx         = mv_indx;
      cmd              = cmd_UART;
      cmd_rdy          = 1'b0;
      clr_cmd_rdy_UART = 1'b0;
      resp             = RESP_BUSY;
      case (state)
         IDLE: begin
            cmd              = cmd_UART;
            cmd_rdy          = cmd_rdy_UART;
            clr_cmd_rdy_UART = clr_cmd_rdy;
            resp             = RESP_ACK;
            if (start_tour) begin
               nxt_indx  = 5'd0;
               nxt_state = VERT;
            end
         end
         VERT: begin
            cmd     = vert_cmd;
            cmd_rdy = 1'b1;
            if (clr_cmd_rdy) nxt_state = VERT_WAIT;
         end
         VERT_WAIT: begin
            cmd = vert_cmd;
            if (send_resp) nxt_state = HORZ;
         end
         HORZ: begin
            cmd     = horz_cmd;
            cmd_rdy = 1'b1;
            if (clr_cmd_rdy) nxt_state = HORZ_WAIT;
         end
         HORZ_WAIT: begin
            cmd = horz_cmd;
            // The final leg's response reports completion rather than progress
            if (last_move) resp = RESP_ACK;
            if (send_resp) begin
               if (last_move) begin
                  nxt_indx  = 5'd0;
                  nxt_state = IDLE;
               end else begin
                  nxt_indx  = mv_indx + 5'd1;
                  nxt_state = VERT;
               end
            end
         end
         default: begin
            nxt_state = IDLE;
            nxt_indx  = 5'd0;
         end
      endcase
   end

endmodule

// File: tb/tb_tour_cmd_sequencer.sv
// Bench for tour_cmd_sequencer: decode table, handshake corner cases, randomized full tours.
// Latency: n/a.
// Backpressure: a model cmd_proc acknowledges with random delays.
module tb_tour_cmd_sequencer;

   localparam int NUM_MOVES = 24;

   logic        clk = 1'b0;
   logic        rst;
   logic        start_tour;
   logic [7:0]  move;
   logic [4:0]  mv_indx;
   logic [15:0] cmd_UART;
   logic        cmd_rdy_UART;
   logic        clr_cmd_rdy;
   logic        clr_cmd_rdy_UART;
   logic        send_resp;
   logic [15:0] cmd;
   logic        cmd_rdy;
   logic [7:0]  resp;

   // Solver model: the tour as an array indexed by the replay index
   logic [7:0] tour [0:31];
   assign move = tour[mv_indx];

   int n_tests = 0;
   int n_fail  = 0;
   int issued;

   // Knight displacement per one-hot bit: +dy is north, +dx is east
   int dy_tab [0:7] = '{2, 2, 1, -1, -2, -2, -1, 1};
   int dx_tab [0:7] = '{-1, 1, -2, -2, -1, 1, 2, 2};

   tour_cmd_sequencer dut (
      .clk              (clk),
      .rst              (rst),
      .start_tour       (start_tour),
      .move             (move),
      .mv_indx          (mv_indx),
      .cmd_UART         (cmd_UART),
      .cmd_rdy_UART     (cmd_rdy_UART),
      .clr_cmd_rdy      (clr_cmd_rdy),
      .clr_cmd_rdy_UART (clr_cmd_rdy_UART),
      .send_resp        (send_resp),
      .cmd              (cmd),
      .cmd_rdy          (cmd_rdy),
      .resp             (resp)
   );

   always #10 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
      $fatal(1, "watchdog");
   end

   // Reference: command word for one leg of a move, from the displacement tables
   function automatic logic [15:0] ref_cmd(input logic [7:0] mv, input bit horz);
      int d;
      logic [7:0] hdg;
      logic [3:0] op;
      op = horz ? 4'h3 : 4'h2;
      d  = 0;
      if ($countones(mv) != 1) return {op, 8'h00, 4'h0};
      for (int i = 0; i < 8; i++)
         if (mv[i]) d = horz ? dx_tab[i] : dy_tab[i];
      if (horz) hdg = (d < 0) ? 8'h3F : 8'hBF;
      else      hdg = (d > 0) ? 8'h00 : 8'h7F;
      return {op, hdg, 4'((d < 0) ? -d : d)};
   endfunction

   // Heading of a zero-length leg is unconstrained; compare opcode and squares only
   function automatic logic [15:0] mask_for(input logic [7:0] mv);
      return ($countones(mv) == 1) ? 16'hFFFF : 16'hF00F;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic noise();
      cmd_rdy_UART = 1'($urandom_range(0, 1));
      start_tour   = 1'($urandom_range(0, 1));
   endtask

   task automatic start_it();
      cmd_rdy_UART = 1'b0;
      start_tour   = 1'b1;
      @(negedge clk);
      start_tour = 1'b0;
      chk("start_latency", cmd_rdy, 1);
   endtask

   task automatic wait_rdy(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (cmd_rdy) begin
            ok = 1'b1;
            break;
         end
         noise();
         @(negedge clk);
      end
      if (!ok) begin
         n_tests++;
         n_fail++;
         $display("FAIL wait_rdy: cmd_rdy not seen within 50 cycles");
      end
   endtask

   // Model cmd_proc: consume command k (two per move), optionally send its response
   task automatic one_cmd(input int k, input bit do_resp, output bit ok);
      logic [15:0] e;
      logic [15:0] m;
      wait_rdy(ok);
      if (!ok) return;
      e = ref_cmd(tour[k/2], (k % 2) == 1);
      m = mask_for(tour[k/2]);
      chk("cmd", cmd & m, e & m);
      chk("mv_indx", mv_indx, k / 2);
      repeat ($urandom_range(0, 2)) begin
         noise();
         @(negedge clk);
      end
      chk("cmd_hold", {cmd_rdy, cmd & m}, {1'b1, e & m});
      clr_cmd_rdy = 1'b1;
      #1;
      chk("clr_fwd_busy", clr_cmd_rdy_UART, 0);
      @(negedge clk);
      clr_cmd_rdy = 1'b0;
      chk("rdy_drop", cmd_rdy, 0);
      repeat ($urandom_range(0, 3)) begin
         noise();
         @(negedge clk);
      end
      chk("resp", resp, (k == 2 * NUM_MOVES - 1) ? 8'hA5 : 8'h5A);
      if (do_resp) begin
         start_tour = 1'b0;
         send_resp  = 1'b1;
         @(negedge clk);
         send_resp = 1'b0;
         issued++;
      end
   endtask

   typedef struct {
      logic [7:0]  mv;
      logic [15:0] vcmd;
      logic [15:0] hcmd;
      logic [15:0] mask;
   } vec_t;

   vec_t vecs [10];

   initial begin
      bit ok;
      rst = 1'b1; start_tour = 1'b0; cmd_UART = 16'h0; cmd_rdy_UART = 1'b0;
      clr_cmd_rdy = 1'b0; send_resp = 1'b0;
      for (int i = 0; i < 32; i++) tour[i] = 8'h00;

      vecs[0] = '{8'h01, 16'h2002, 16'h33F1, 16'hFFFF};
      vecs[1] = '{8'h02, 16'h2002, 16'h3BF1, 16'hFFFF};
      vecs[2] = '{8'h04, 16'h2001, 16'h33F2, 16'hFFFF};
      vecs[3] = '{8'h08, 16'h27F1, 16'h33F2, 16'hFFFF};
      vecs[4] = '{8'h10, 16'h27F2, 16'h33F1, 16'hFFFF};
      vecs[5] = '{8'h20, 16'h27F2, 16'h3BF1, 16'hFFFF};
      vecs[6] = '{8'h40, 16'h27F1, 16'h3BF2, 16'hFFFF};
      vecs[7] = '{8'h80, 16'h2001, 16'h3BF2, 16'hFFFF};
      vecs[8] = '{8'h00, 16'h2000, 16'h3000, 16'hF00F};
      vecs[9] = '{8'h03, 16'h2000, 16'h3000, 16'hF00F};

      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("reset_indx", mv_indx, 0);
      chk("reset_resp", resp, 8'hA5);
      chk("reset_rdy", cmd_rdy, 0);

      // UART passthrough while idle
      cmd_UART = 16'h2003; cmd_rdy_UART = 1'b1; clr_cmd_rdy = 1'b1;
      #1;
      chk("uart_cmd", cmd, 16'h2003);
      chk("uart_rdy", cmd_rdy, 1);
      chk("uart_clr_fwd", clr_cmd_rdy_UART, 1);
      @(negedge clk);
      clr_cmd_rdy = 1'b0; cmd_rdy_UART = 1'b0;
      #1;
      chk("uart_rdy_low", cmd_rdy, 0);

      // Decode table: one move per vector, both legs, then abort with reset
      for (int v = 0; v < 10; v++) begin
         tour[0] = vecs[v].mv;
         start_it();
         chk($sformatf("vert_%02h", vecs[v].mv), cmd & vecs[v].mask, vecs[v].vcmd & vecs[v].mask);
         clr_cmd_rdy = 1'b1;
         @(negedge clk);
         clr_cmd_rdy = 1'b0;
         send_resp   = 1'b1;
         @(negedge clk);
         send_resp = 1'b0;
         chk("horz_latency", cmd_rdy, 1);
         chk($sformatf("horz_%02h", vecs[v].mv), cmd & vecs[v].mask, vecs[v].hcmd & vecs[v].mask);
         do_reset();
      end
      tour[0] = 8'h00;

      // clr_cmd_rdy and send_resp together advance one step per cycle
      tour[0] = 8'h80;
      start_it();
      clr_cmd_rdy = 1'b1; send_resp = 1'b1;
      @(negedge clk);
      chk("both_vert_wait", cmd_rdy, 0);
      @(negedge clk);
      chk("both_horz_rdy", cmd_rdy, 1);
      chk("both_horz_cmd", cmd, 16'h3BF2);
      send_resp = 1'b0;
      @(negedge clk);
      clr_cmd_rdy = 1'b0;

      // In HORZ_WAIT: start_tour, UART command and clr_cmd_rdy are all ignored
      start_tour = 1'b1; cmd_rdy_UART = 1'b1; clr_cmd_rdy = 1'b1;
      #1;
      chk("busy_clr_fwd", clr_cmd_rdy_UART, 0);
      chk("busy_uart_rdy", cmd_rdy, 0);
      @(negedge clk);
      chk("busy_rdy_still", cmd_rdy, 0);
      chk("busy_indx", mv_indx, 0);
      chk("busy_resp", resp, 8'h5A);
      start_tour = 1'b0; cmd_rdy_UART = 1'b0; clr_cmd_rdy = 1'b0;
      do_reset();

      // Randomized full tours against the reference model
      cmd_UART = 16'hFFFF;
      for (int t = 0; t < 3; t++) begin
         for (int i = 0; i < NUM_MOVES; i++)
            tour[i] = ($urandom_range(0, 7) == 0) ? 8'h00 : (8'h01 << $urandom_range(0, 7));
         issued = 0;
         start_it();
         for (int k = 0; k < 2 * NUM_MOVES; k++) begin
            one_cmd(k, 1'b1, ok);
            if (!ok) break;
         end
         #1;
         chk("tour_cmds_issued", issued, 2 * NUM_MOVES);
         chk("tour_end_indx", mv_indx, 0);
         chk("tour_end_resp", resp, 8'hA5);
         chk("tour_end_uart", cmd_rdy, cmd_rdy_UART);
         start_tour = 1'b0; cmd_rdy_UART = 1'b0;
         @(negedge clk);
      end

      // Reset in HORZ_WAIT at index 7 aborts the replay
      for (int i = 0; i < NUM_MOVES; i++) tour[i] = 8'h01 << (i % 8);
      issued = 0;
      start_it();
      for (int k = 0; k < 15; k++) begin
         one_cmd(k, 1'b1, ok);
         if (!ok) break;
      end
      one_cmd(15, 1'b0, ok);
      start_tour = 1'b0;
      chk("abort_pre_indx", mv_indx, 7);
      cmd_rdy_UART = 1'b1;
      do_reset();
      #1;
      chk("abort_indx", mv_indx, 0);
      chk("abort_uart_rdy", cmd_rdy, 1);
      chk("abort_resp", resp, 8'hA5);
      cmd_rdy_UART = 1'b0;
      send_resp    = 1'b1;
      @(negedge clk);
      send_resp = 1'b0;
      repeat (3) @(negedge clk);
      chk("abort_no_more_cmds", cmd_rdy, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
